// File: rtl/prog_counter_pkg.sv
// -----------------------------------------------------------------------------
// prog_counter_pkg
//   Shared types and defaults for the programmable event counter.
//   - dir_e  : count direction (DIR_UP / DIR_DOWN)
//   - mode_e : periodic or one-shot operation
//   - DEFAULT_WIDTH / DEFAULT_PRESCALE_WIDTH : default parameter values
// -----------------------------------------------------------------------------
package prog_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_PRESCALE_WIDTH = 8;

endpackage : prog_counter_pkg

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Clock-enable divider for prog_counter. Produces a combinational TICK_OUT
//   once every PRESCALE_IN+1 enabled, non-held cycles.
//
// Ports:
//   CLK          in  clock, rising edge
//   RESET        in  asynchronous, active-high reset (pc -> 0)
//   ENABLE_IN    in  advance the divider this cycle
//   HOLD_IN      in  freeze the divider and suppress the tick (one-shot halt)
//   CLR_IN       in  synchronous clear of pc (counter clear or load)
//   PRESCALE_IN  in  divide ratio minus one, sampled live
//   TICK_OUT     out combinational tick to the count stage
// -----------------------------------------------------------------------------
module counter_prescaler #(
  parameter int PRESCALE_WIDTH = prog_counter_pkg::DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE_IN,
  input  logic                      HOLD_IN,
  input  logic                      CLR_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE_IN,
  output logic                      TICK_OUT
);

  logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
  logic                      advance;

  assign advance = ENABLE_IN && !HOLD_IN;

  // Greater-or-equal rather than equality: if PRESCALE_IN is lowered below
  // the running pc, the next enabled cycle ticks instead of wrapping pc.
  // This also means pc never exceeds PRESCALE_IN-1 before incrementing, so
  // the +1 below cannot overflow.
  assign TICK_OUT = advance && (pc_q >= PRESCALE_IN);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (CLR_IN) begin
      pc_d = '0;
    end else if (advance) begin
      pc_d = TICK_OUT ? '0 : pc_q + PRESCALE_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule : counter_prescaler

// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//   Runtime-programmable up/down event counter with prescaler, synchronous
//   clear/load and one-shot mode. TRIG_OUT of one instance can drive
//   ENABLE_IN of the next to build timing chains.
//
// Ports:
//   CLK          in  clock, rising edge
//   RESET        in  asynchronous, active-high reset
//   ENABLE_IN    in  count enable (prescaler advances only when high)
//   CLEAR_IN     in  synchronous clear to the start value of DIR_IN
//   LOAD_IN      in  synchronous load of LOAD_VAL
//   LOAD_VAL     in  value loaded when LOAD_IN=1
//   MAX_IN       in  terminal value, sampled live
//   DIR_IN       in  0 = up, 1 = down
//   ONESHOT_IN   in  0 = periodic, 1 = stop after first terminal event
//   PRESCALE_IN  in  tick every PRESCALE_IN+1 enabled cycles
//   COUNT        out current count, registered
//   TRIG_OUT     out one-cycle pulse after a terminal tick, registered
//   DONE_OUT     out sticky one-shot expired flag
// -----------------------------------------------------------------------------
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE_IN,
  input  logic                      CLEAR_IN,
  input  logic                      LOAD_IN,
  input  logic [WIDTH-1:0]          LOAD_VAL,
  input  logic [WIDTH-1:0]          MAX_IN,
  input  logic                      DIR_IN,
  input  logic                      ONESHOT_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE_IN,
  output logic [WIDTH-1:0]          COUNT,
  output logic                      TRIG_OUT,
  output logic                      DONE_OUT
);

  dir_e             dir;
  mode_e            mode;
  logic             tick;
  logic             halted;
  logic             terminal;
  logic [WIDTH-1:0] count_q, count_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;

  assign dir  = dir_e'(DIR_IN);
  assign mode = mode_e'(ONESHOT_IN);

  // The run/halted state lives entirely in DONE_OUT and ONESHOT_IN: dropping
  // ONESHOT_IN releases the freeze without clearing the sticky flag.
  assign halted = (mode == MODE_ONESHOT) && done_q;

  counter_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE_IN   (ENABLE_IN),
    .HOLD_IN     (halted),
    .CLR_IN      (CLEAR_IN || LOAD_IN),
    .PRESCALE_IN (PRESCALE_IN),
    .TICK_OUT    (tick)
  );

  // Priority: CLEAR_IN > LOAD_IN > tick. The terminal compare uses >= in up
  // mode so a count above MAX_IN (after a load or a MAX_IN change) wraps on
  // the next tick, and MAX_IN = all-ones wraps without an overflow path.
  always_comb begin
    count_d  = count_q;
    trig_d   = 1'b0;
    done_d   = done_q;
    terminal = 1'b0;
    if (CLEAR_IN) begin
      count_d = (dir == DIR_DOWN) ? MAX_IN : '0;
      done_d  = 1'b0;
    end else if (LOAD_IN) begin
      count_d = LOAD_VAL;
      done_d  = 1'b0;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        terminal = (count_q >= MAX_IN);
        count_d  = terminal ? '0 : count_q + WIDTH'(1);
      end else begin
        // Down mode only terminates at zero; a count above MAX_IN simply
        // keeps decrementing.
        terminal = (count_q == '0);
        count_d  = terminal ? MAX_IN : count_q - WIDTH'(1);
      end
      trig_d = terminal;
      if (terminal && (mode == MODE_ONESHOT)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
    end
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;
  assign DONE_OUT = done_q;

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// -----------------------------------------------------------------------------
// tb_prog_counter
//   Directed self-checking bench for prog_counter (WIDTH=16, PRESCALE_WIDTH=8).
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_prog_counter;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk;
  logic          reset;
  logic          enable_in;
  logic          clear_in;
  logic          load_in;
  logic [W-1:0]  load_val;
  logic [W-1:0]  max_in;
  logic          dir_in;
  logic          oneshot_in;
  logic [PW-1:0] prescale_in;
  logic [W-1:0]  count;
  logic          trig_out;
  logic          done_out;

  int n_vec = 0;
  int n_err = 0;

  prog_counter #(
    .WIDTH          (W),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .ENABLE_IN   (enable_in),
    .CLEAR_IN    (clear_in),
    .LOAD_IN     (load_in),
    .LOAD_VAL    (load_val),
    .MAX_IN      (max_in),
    .DIR_IN      (dir_in),
    .ONESHOT_IN  (oneshot_in),
    .PRESCALE_IN (prescale_in),
    .COUNT       (count),
    .TRIG_OUT    (trig_out),
    .DONE_OUT    (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int exp_cnt, input bit exp_trig, input bit exp_done);
    check({tag, ".count"}, 32'(count), 32'(exp_cnt));
    check({tag, ".trig"},  32'(trig_out), 32'(exp_trig));
    check({tag, ".done"},  32'(done_out), 32'(exp_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;

    reset       = 1'b1;
    enable_in   = 1'b0;
    clear_in    = 1'b0;
    load_in     = 1'b0;
    load_val    = '0;
    max_in      = 16'd4;
    dir_in      = 1'b0;
    oneshot_in  = 1'b0;
    prescale_in = '0;

    // Reset state
    #2;
    chk("reset", 0, 1'b0, 1'b0);
    check("reset.pc", 32'(dut.u_prescaler.pc_q), 32'd0);
    #10;
    reset     = 1'b0;
    enable_in = 1'b1;

    // 1. Legacy equivalence: MAX=4, up, prescale 0
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_cnt = i % 5;
      chk($sformatf("legacy%0d", i), exp_cnt, exp_cnt == 0, 1'b0);
    end

    // 2. Prescale 2, MAX 3, with an enable gap
    clear_pulse();
    chk("pre.clear", 0, 1'b0, 1'b0);
    prescale_in = 8'd2;
    max_in      = 16'd3;
    step(); chk("pre.e1", 0, 1'b0, 1'b0);
    step(); chk("pre.e2", 0, 1'b0, 1'b0);
    step(); chk("pre.e3", 1, 1'b0, 1'b0);
    step(); chk("pre.e4", 1, 1'b0, 1'b0);
    enable_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre.gap", 1, 1'b0, 1'b0);
    check("pre.gap.pc", 32'(dut.u_prescaler.pc_q), 32'd1);
    enable_in = 1'b1;
    step(); chk("pre.r1", 1, 1'b0, 1'b0);
    step(); chk("pre.r2", 2, 1'b0, 1'b0);
    step(); step(); step(); chk("pre.r5", 3, 1'b0, 1'b0);
    step(); step(); step(); chk("pre.wrap", 0, 1'b1, 1'b0);
    step(); chk("pre.after", 0, 1'b0, 1'b0);

    // 3. Down mode, MAX 3
    prescale_in = '0;
    dir_in      = 1'b1;
    clear_pulse();
    chk("down.clear", 3, 1'b0, 1'b0);
    step(); chk("down.2", 2, 1'b0, 1'b0);
    step(); chk("down.1", 1, 1'b0, 1'b0);
    step(); chk("down.0", 0, 1'b0, 1'b0);
    step(); chk("down.wrap", 3, 1'b1, 1'b0);
    step(); chk("down.2b", 2, 1'b0, 1'b0);

    // 4. One-shot, MAX 2, up
    dir_in = 1'b0;
    max_in = 16'd2;
    clear_pulse();
    chk("os.clear", 0, 1'b0, 1'b0);
    oneshot_in = 1'b1;
    step(); chk("os.1", 1, 1'b0, 1'b0);
    step(); chk("os.2", 2, 1'b0, 1'b0);
    step(); chk("os.wrap", 0, 1'b1, 1'b1);
    step(); step(); step();
    chk("os.frozen", 0, 1'b0, 1'b1);
    load_in  = 1'b1;
    load_val = 16'd1;
    step(); chk("os.load", 1, 1'b0, 1'b0);
    load_in = 1'b0;
    step(); chk("os.r2", 2, 1'b0, 1'b0);
    step(); chk("os.rwrap", 0, 1'b1, 1'b1);
    oneshot_in = 1'b0;
    step(); chk("os.resume", 1, 1'b0, 1'b1);

    // 5. Load above max, clear/load priority
    max_in   = 16'd5;
    load_val = 16'd9;
    load_in  = 1'b1;
    step(); chk("ld.9", 9, 1'b0, 1'b0);
    load_in = 1'b0;
    step(); chk("ld.wrap", 0, 1'b1, 1'b0);
    load_in  = 1'b1;
    clear_in = 1'b1;
    load_val = 16'd7;
    step(); chk("prio.up", 0, 1'b0, 1'b0);
    dir_in = 1'b1;
    step(); chk("prio.down", 5, 1'b0, 1'b0);
    load_in  = 1'b0;
    clear_in = 1'b0;
    dir_in   = 1'b0;

    // MAX 0: trigger on every tick, both directions
    max_in = '0;
    clear_pulse();
    step(); chk("max0.up1", 0, 1'b1, 1'b0);
    step(); chk("max0.up2", 0, 1'b1, 1'b0);
    dir_in = 1'b1;
    step(); chk("max0.down", 0, 1'b1, 1'b0);
    dir_in = 1'b0;

    // Full-range wrap
    max_in   = 16'hFFFF;
    load_val = 16'hFFFE;
    load_in  = 1'b1;
    step(); load_in = 1'b0;
    step(); chk("full.ffff", 32'hFFFF, 1'b0, 1'b0);
    step(); chk("full.wrap", 0, 1'b1, 1'b0);

    // Lowering PRESCALE_IN below pc ticks on the next enabled cycle
    prescale_in = 8'd5;
    clear_pulse();
    step(); step(); step();
    chk("lower.pre", 0, 1'b0, 1'b0);
    check("lower.pc", 32'(dut.u_prescaler.pc_q), 32'd3);
    prescale_in = 8'd1;
    step(); chk("lower.tick", 1, 1'b0, 1'b0);

    // 6. Asynchronous reset mid-operation (COUNT=3, pc=1)
    max_in = 16'd10;
    clear_pulse();
    for (int i = 0; i < 7; i++) step();
    chk("rst.pre", 3, 1'b0, 1'b0);
    check("rst.pre.pc", 32'(dut.u_prescaler.pc_q), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst.async", 0, 1'b0, 1'b0);
    check("rst.async.pc", 32'(dut.u_prescaler.pc_q), 32'd0);
    #2;
    reset = 1'b0;
    step(); chk("rst.e1", 0, 1'b0, 1'b0);
    step(); chk("rst.e2", 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_prog_counter
